// File: rtl/cmd_defines.sv
// cmd_defines: shared constants for the host command protocol receive path.
// Holds the START byte, header byte indices, OP bit positions, the receive
// FSM state encodings and the packed request record carried to the handler.
package cmd_defines;

    localparam logic [7:0] CMD_START = 8'hA5;

    // Header byte positions, counted from the first byte after START.
    localparam logic [2:0] HDR_OP   = 3'd0;
    localparam logic [2:0] HDR_SZ   = 3'd1;
    localparam logic [2:0] HDR_A0   = 3'd2;
    localparam logic [2:0] HDR_A1   = 3'd3;
    localparam logic [2:0] HDR_A2   = 3'd4;
    localparam logic [2:0] HDR_A3   = 3'd5;
    localparam logic [2:0] HDR_CRC  = 3'd6;
    localparam logic [2:0] HDR_LAST = HDR_CRC;

    // OP byte layout.
    localparam int OP_WR_BIT    = 0;
    localparam int OP_AINCR_BIT = 3;
    localparam int OP_WSIZE_LSB = 4;

    // Receive FSM encodings.
    localparam logic [1:0] ST_WAITFORSTART = 2'd0;
    localparam logic [1:0] ST_RECV_HEADER  = 2'd1;
    localparam logic [1:0] ST_HANDLE_MREQ  = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  wsize;
        logic        aincr;
        logic [7:0]  size;
        logic [31:0] addr;
    } mreq_t;

endpackage

// File: rtl/crc8.sv
// crc8: combinational single-byte CRC-8 update, polynomial 0x07, MSB first.
// Ports:
//   i_data - byte to fold in
//   i_crc  - running CRC value (0x00 at frame start)
//   o_crc  - updated CRC value
module crc8 (
    input  logic [7:0] i_data,
    input  logic [7:0] i_crc,
    output logic [7:0] o_crc
);

    logic [7:0] crc_work;

    always_comb begin
        crc_work = i_crc ^ i_data;
        for (int i = 0; i < 8; i++) begin
            if (crc_work[7]) begin
                crc_work = {crc_work[6:0], 1'b0} ^ 8'h07;
            end else begin
                crc_work = {crc_work[6:0], 1'b0};
            end
        end
        o_crc = crc_work;
    end

endmodule

// File: rtl/cmd_rx.sv
// cmd_rx: receive side of the host command protocol.
// Hunts for the START byte, collects OP, SZ, A0..A3 and CRC, checks the CRC
// and then holds a memory request towards the handler. While the request is
// held the input stream is wired straight through to the payload port, so
// the handler drains MWRITE data at its own pace.
// Optional header timeout: define CMD_RX_TIMEOUT_EN.
// Ports:
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_st_data/valid, o_st_ready - command byte stream from the host link
//   o_mreq_valid, i_mreq_ready  - request handshake with the handler
//   o_mreq_wr/wsize/aincr/size/addr - decoded request fields
//   o_rx_data/valid, i_rx_data_ready - MWRITE payload passthrough
//   o_crc_err                 - one-cycle pulse on header CRC mismatch
//   o_timeout                 - one-cycle pulse on header timeout
module cmd_rx
    import cmd_defines::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_st_data,
    input  logic        i_st_valid,
    output logic        o_st_ready,
    output logic        o_mreq_valid,
    input  logic        i_mreq_ready,
    output logic        o_mreq_wr,
    output logic [1:0]  o_mreq_wsize,
    output logic        o_mreq_aincr,
    output logic [7:0]  o_mreq_size,
    output logic [31:0] o_mreq_addr,
    output logic [7:0]  o_rx_data,
    output logic        o_rx_data_valid,
    input  logic        i_rx_data_ready,
    output logic        o_crc_err,
    output logic        o_timeout
);

    logic [1:0] state_reg, state_next;
    logic [2:0] idx_reg, idx_next;
    logic [7:0] crc_reg, crc_next;
    mreq_t      req_reg, req_next;
    logic       crc_err_reg, crc_err_next;

    logic       in_wait, in_header, in_handle;
    logic       st_fire;
    logic [7:0] crc_in, crc_out;
    logic       tmo_hit;

    assign in_wait   = (state_reg == ST_WAITFORSTART);
    assign in_header = (state_reg == ST_RECV_HEADER);
    assign in_handle = (state_reg == ST_HANDLE_MREQ);

    // During a request the stream belongs to the handler; otherwise we
    // always accept. An illegal state accepts nothing for its single cycle.
    assign o_st_ready = in_handle ? i_rx_data_ready : (in_wait | in_header);
    assign st_fire    = i_st_valid & o_st_ready;

    // START is folded into a fresh CRC, so the seed is 0 while hunting.
    assign crc_in = in_wait ? 8'h00 : crc_reg;

    crc8 u_crc8 (
        .i_data (i_st_data),
        .i_crc  (crc_in),
        .o_crc  (crc_out)
    );

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        crc_next     = crc_reg;
        req_next     = req_reg;
        crc_err_next = 1'b0;

        case (state_reg)
            ST_WAITFORSTART: begin
                if (st_fire && (i_st_data == CMD_START)) begin
                    crc_next   = crc_out;
                    idx_next   = HDR_OP;
                    state_next = ST_RECV_HEADER;
                end
            end

            ST_RECV_HEADER: begin
                if (st_fire) begin
                    // Every header byte is data, including 0xA5.
                    case (idx_reg)
                        HDR_OP: begin
                            req_next.wr    = i_st_data[OP_WR_BIT];
                            req_next.aincr = i_st_data[OP_AINCR_BIT];
                            req_next.wsize = i_st_data[OP_WSIZE_LSB +: 2];
                        end
                        HDR_SZ: req_next.size       = i_st_data;
                        HDR_A0: req_next.addr[7:0]   = i_st_data;
                        HDR_A1: req_next.addr[15:8]  = i_st_data;
                        HDR_A2: req_next.addr[23:16] = i_st_data;
                        HDR_A3: req_next.addr[31:24] = i_st_data;
                        HDR_LAST: begin
                            if (i_st_data == crc_reg) begin
                                state_next = ST_HANDLE_MREQ;
                            end else begin
                                crc_err_next = 1'b1;
                                state_next   = ST_WAITFORSTART;
                            end
                        end
                        default: state_next = ST_WAITFORSTART;
                    endcase
                    if (idx_reg < HDR_LAST) begin
                        crc_next = crc_out;
                        idx_next = idx_reg + 3'd1;
                    end
                end else if (tmo_hit) begin
                    state_next = ST_WAITFORSTART;
                end
            end

            ST_HANDLE_MREQ: begin
                // A payload byte moving in this cycle is still delivered by
                // the passthrough; only the request itself closes.
                if (i_mreq_ready) begin
                    state_next = ST_WAITFORSTART;
                end
            end

            default: state_next = ST_WAITFORSTART;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_WAITFORSTART;
            idx_reg     <= HDR_OP;
            crc_reg     <= 8'h00;
            req_reg     <= '0;
            crc_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            crc_reg     <= crc_next;
            req_reg     <= req_next;
            crc_err_reg <= crc_err_next;
        end
    end

`ifdef CMD_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_inc;
    logic             timeout_reg;

    // The counter holds the number of idle header cycles already seen; the
    // idle cycle that brings it to TIMEOUT_CYCLES is the one that fires.
    assign tmo_cnt_inc = tmo_cnt_reg + 1'b1;
    assign tmo_hit     = in_header && (tmo_cnt_inc == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk) begin
        if (i_rst || !in_header || st_fire) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_inc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= tmo_hit && !st_fire;
        end
    end

    assign o_timeout = timeout_reg;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_mreq_valid    = in_handle;
    assign o_mreq_wr       = req_reg.wr;
    assign o_mreq_wsize    = req_reg.wsize;
    assign o_mreq_aincr    = req_reg.aincr;
    assign o_mreq_size     = req_reg.size;
    assign o_mreq_addr     = req_reg.addr;
    assign o_rx_data       = in_handle ? i_st_data : 8'h00;
    assign o_rx_data_valid = in_handle & i_st_valid;
    assign o_crc_err       = crc_err_reg;

endmodule

// File: tb/tb_cmd_rx.sv
// tb_cmd_rx: directed self-checking bench for cmd_rx.
// Inputs are driven and outputs sampled on the falling edge.
module tb_cmd_rx;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_st_data;
    logic        i_st_valid;
    logic        o_st_ready;
    logic        o_mreq_valid;
    logic        i_mreq_ready;
    logic        o_mreq_wr;
    logic [1:0]  o_mreq_wsize;
    logic        o_mreq_aincr;
    logic [7:0]  o_mreq_size;
    logic [31:0] o_mreq_addr;
    logic [7:0]  o_rx_data;
    logic        o_rx_data_valid;
    logic        i_rx_data_ready;
    logic        o_crc_err;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;
    int crc_err_cnt = 0;
    int tmo_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] pay [4];

    always #5 clk = ~clk;

    cmd_rx #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_st_data       (i_st_data),
        .i_st_valid      (i_st_valid),
        .o_st_ready      (o_st_ready),
        .o_mreq_valid    (o_mreq_valid),
        .i_mreq_ready    (i_mreq_ready),
        .o_mreq_wr       (o_mreq_wr),
        .o_mreq_wsize    (o_mreq_wsize),
        .o_mreq_aincr    (o_mreq_aincr),
        .o_mreq_size     (o_mreq_size),
        .o_mreq_addr     (o_mreq_addr),
        .o_rx_data       (o_rx_data),
        .o_rx_data_valid (o_rx_data_valid),
        .i_rx_data_ready (i_rx_data_ready),
        .o_crc_err       (o_crc_err),
        .o_timeout       (o_timeout)
    );

    // Passive monitors: payload bytes handed over, pulse counts.
    always @(posedge clk) begin
        if (!i_rst) begin
            if (o_rx_data_valid && i_rx_data_ready) rx_q.push_back(o_rx_data);
            if (o_crc_err) crc_err_cnt++;
            if (o_timeout) tmo_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int k = 0; k < 8; k++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_st_data  = b;
        i_st_valid = 1'b1;
        @(negedge clk);
        i_st_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] sz,
                              input logic [31:0] addr, input bit bad, input int stall);
        logic [7:0] hdr [7];
        logic [7:0] c;
        hdr = '{8'hA5, op, sz, addr[7:0], addr[15:8], addr[23:16], addr[31:24]};
        c = 8'h00;
        for (int i = 0; i < 7; i++) begin
            c = crc_upd(c, hdr[i]);
            send_byte(hdr[i]);
            if (i == 2) repeat (stall) @(negedge clk);
        end
        check("pre_crc_valid", {31'd0, o_mreq_valid}, 32'd0);
        send_byte(bad ? (c ^ 8'h01) : c);
        $display("frame op=%h sz=%h addr=%h bad=%0d stall=%0d -> valid=%0d", op, sz, addr, bad, stall, o_mreq_valid);
    endtask

    task automatic check_req(input string tag, input logic wr, input logic aincr,
                             input logic [1:0] wsize, input logic [7:0] sz, input logic [31:0] addr);
        check({tag, "_valid"}, {31'd0, o_mreq_valid}, 32'd1);
        check({tag, "_wr"},    {31'd0, o_mreq_wr},    {31'd0, wr});
        check({tag, "_aincr"}, {31'd0, o_mreq_aincr}, {31'd0, aincr});
        check({tag, "_wsize"}, {30'd0, o_mreq_wsize}, {30'd0, wsize});
        check({tag, "_size"},  {24'd0, o_mreq_size},  {24'd0, sz});
        check({tag, "_addr"},  o_mreq_addr,           addr);
    endtask

    task automatic complete_req(input string tag);
        i_mreq_ready = 1'b1;
        @(negedge clk);
        i_mreq_ready = 1'b0;
        check({tag, "_done"}, {31'd0, o_mreq_valid}, 32'd0);
        check({tag, "_rdy"},  {31'd0, o_st_ready},   32'd1);
    endtask

    initial begin
        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        i_rst = 1'b1; i_st_data = 8'h00; i_st_valid = 1'b0;
        i_mreq_ready = 1'b0; i_rx_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",   {31'd0, o_st_ready},      32'd1);
        check("rst_mvalid",  {31'd0, o_mreq_valid},    32'd0);
        check("rst_addr",    o_mreq_addr,              32'd0);
        check("rst_crcerr",  {31'd0, o_crc_err},       32'd0);
        check("rst_timeout", {31'd0, o_timeout},       32'd0);
        check("rst_rxvalid", {31'd0, o_rx_data_valid}, 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        // MWRITE with leading junk.
        send_byte(8'h00);
        send_byte(8'h13);
        send_frame(8'h01, 8'h03, 32'h12345678, 1'b0, 0);
        check_req("mw", 1'b1, 1'b0, 2'd0, 8'h03, 32'h12345678);
        check("mw_crcerr", 32'(crc_err_cnt), 32'd0);

        // Payload with the handler alternating ready; last byte completes.
        for (int i = 0; i < 4; i++) begin
            i_st_data = pay[i]; i_st_valid = 1'b1; i_rx_data_ready = 1'b0;
            @(negedge clk);
            check("pay_hold_ready", {31'd0, o_st_ready},   32'd0);
            check("pay_hold_valid", {31'd0, o_mreq_valid}, 32'd1);
            check("pay_data",       {24'd0, o_rx_data},    {24'd0, pay[i]});
            i_rx_data_ready = 1'b1;
            i_mreq_ready = (i == 3);
            @(negedge clk);
            $display("payload byte %0d = %h delivered=%0d", i, pay[i], rx_q.size());
        end
        i_st_valid = 1'b0; i_rx_data_ready = 1'b0; i_mreq_ready = 1'b0;
        check("pay_done", {31'd0, o_mreq_valid}, 32'd0);
        check("pay_cnt", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < rx_q.size()) check("pay_order", {24'd0, rx_q[i]}, {24'd0, pay[i]});

        // MREAD right after completion; nothing consumed while held.
        send_frame(8'h38, 8'hFF, 32'hFFFFFFFF, 1'b0, 0);
        check_req("mr", 1'b0, 1'b1, 2'd3, 8'hFF, 32'hFFFFFFFF);
        i_st_data = 8'h55; i_st_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mr_noconsume", {31'd0, o_st_ready}, 32'd0);
            check("mr_pass_valid", {31'd0, o_rx_data_valid}, 32'd1);
        end
        check("mr_rxcnt", 32'(rx_q.size()), 32'd4);
        i_st_valid = 1'b0;
        complete_req("mr");

        // Corrupted CRC then a good frame.
        send_frame(8'h00, 8'h10, 32'h00000080, 1'b1, 0);
        check("crc_pulse", {31'd0, o_crc_err},    32'd1);
        check("crc_nomreq", {31'd0, o_mreq_valid}, 32'd0);
        @(negedge clk);
        check("crc_pulse_end", {31'd0, o_crc_err},    32'd0);
        check("crc_nomreq2",   {31'd0, o_mreq_valid}, 32'd0);
        check("crc_count",     32'(crc_err_cnt),      32'd1);
        send_frame(8'h11, 8'h20, 32'h00000080, 1'b0, 0);
        check_req("after_crc", 1'b1, 1'b0, 2'd1, 8'h20, 32'h00000080);
        complete_req("after_crc");

        // Reset after A1, then a fresh frame.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
        send_byte(8'h44); send_byte(8'h33);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("mid_rst_ready",  {31'd0, o_st_ready},   32'd1);
        check("mid_rst_mvalid", {31'd0, o_mreq_valid}, 32'd0);
        send_frame(8'h00, 8'h08, 32'hDEADBEEF, 1'b0, 0);
        check_req("post_rst", 1'b0, 1'b0, 2'd0, 8'h08, 32'hDEADBEEF);
        complete_req("post_rst");

        // 0xA5 inside the header is plain data.
        send_frame(8'h09, 8'hA5, 32'hA5A5A5A5, 1'b0, 0);
        check_req("a5_data", 1'b1, 1'b1, 2'd0, 8'hA5, 32'hA5A5A5A5);
        complete_req("a5_data");

`ifdef CMD_RX_TIMEOUT_EN
        // 15 idle cycles after SZ survive.
        send_frame(8'h00, 8'h02, 32'hCAFE0000, 1'b0, 15);
        check_req("stall15", 1'b0, 1'b0, 2'd0, 8'h02, 32'hCAFE0000);
        check("stall15_tmo", 32'(tmo_cnt), 32'd0);
        complete_req("stall15");

        // 16 idle cycles after SZ time out.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        repeat (16) @(negedge clk);
        check("tmo_pulse", {31'd0, o_timeout}, 32'd1);
        @(negedge clk);
        check("tmo_pulse_end", {31'd0, o_timeout}, 32'd0);
        check("tmo_count", 32'(tmo_cnt), 32'd1);
        $display("timeout after 16 idle cycles, pulses=%0d", tmo_cnt);
        send_frame(8'h21, 8'h07, 32'h00C0FFEE, 1'b0, 0);
        check_req("post_tmo", 1'b1, 1'b0, 2'd2, 8'h07, 32'h00C0FFEE);
        complete_req("post_tmo");
`else
        // Without the timeout a long stall is harmless.
        send_frame(8'h21, 8'h07, 32'h00C0FFEE, 1'b0, 40);
        check_req("stall40", 1'b1, 1'b0, 2'd2, 8'h07, 32'h00C0FFEE);
        check("stall40_tmo", 32'(tmo_cnt), 32'd0);
        complete_req("stall40");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
